serial_divider: RTL and testbench

Multi-cycle unsigned restoring divider that serves the range-conversion pipeline. It takes the scaled product from the range converter as dividend, divides it by the old-range constant, and returns the quotient for the final offset add. One quotient bit is produced per clock, with a start/done handshake and explicit divide-by-zero handling.

---
 rtl/serial_divider.sv | 124 ++++++++++++
 tb/tb_serial_divider.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done
// handshake, divide-by-zero reported as all-ones quotient with the dividend as remainder.
module serial_divider #(
  parameter int g_Width = 12
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Start,
  input  logic [g_Width-1:0] i_Dividend,
  input  logic [g_Width-1:0] i_Divisor,
  output logic               o_Busy,
  output logic               o_Done,
  output logic [g_Width-1:0] o_Quotient,
  output logic [g_Width-1:0] o_Remainder,
  output logic               o_Div_Zero
);

  localparam int C_CNT_W = $clog2(g_Width + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(g_Width);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [g_Width-1:0] r_quo;
  logic [g_Width:0]   r_rem;
  logic [g_Width-1:0] r_div;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [g_Width-1:0] r_quotient;
  logic [g_Width-1:0] r_remainder;
  logic               r_div_zero;

  logic [g_Width+1:0] w_shift;
  logic [g_Width+1:0] w_trial;
  logic               w_fits;
  logic [g_Width:0]   w_rem_next;
  logic [g_Width-1:0] w_quo_next;

  // One restoring step; the extra top bit of the trial difference acts as the borrow.
  always_comb begin
    w_shift = {r_rem, r_quo[g_Width-1]};
    w_trial = w_shift - {2'b00, r_div};
    w_fits  = ~w_trial[g_Width+1];
    if (w_fits) begin
      w_rem_next = w_trial[g_Width:0];
    end else begin
      w_rem_next = w_shift[g_Width:0];
    end
    w_quo_next = {r_quo[g_Width-2:0], w_fits};
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state     <= S_IDLE;
      r_quo       <= {g_Width{1'b0}};
      r_rem       <= {(g_Width+1){1'b0}};
      r_div       <= {g_Width{1'b0}};
      r_cnt       <= {C_CNT_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= {g_Width{1'b0}};
      r_remainder <= {g_Width{1'b0}};
      r_div_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_Start) begin
            if (i_Divisor == {g_Width{1'b0}}) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_quotient  <= {g_Width{1'b1}};
              r_remainder <= i_Dividend;
              r_div_zero  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_quo   <= i_Dividend;
              r_div   <= i_Divisor;
              r_rem   <= {(g_Width+1){1'b0}};
              r_cnt   <= C_CNT_LOAD;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - C_CNT_ONE;
          if (r_cnt == C_CNT_ONE) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_quo_next;
            r_remainder <= w_rem_next[g_Width-1:0];
            r_div_zero  <= 1'b0;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Busy      = r_busy;
  assign o_Done      = r_done;
  assign o_Quotient  = r_quotient;
  assign o_Remainder = r_remainder;
  assign o_Div_Zero  = r_div_zero;

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider: directed cases plus random divisions
// compared against plain integer division.
module tb_serial_divider;

  localparam int W = 12;

  logic         clk;
  logic         i_Rst_L;
  logic         i_Start;
  logic [W-1:0] i_Dividend;
  logic [W-1:0] i_Divisor;
  logic         o_Busy;
  logic         o_Done;
  logic [W-1:0] o_Quotient;
  logic [W-1:0] o_Remainder;
  logic         o_Div_Zero;

  int n_total = 0;
  int n_bad   = 0;

  serial_divider #(.g_Width(W)) dut (
    .i_Clk       (clk),
    .i_Rst_L     (i_Rst_L),
    .i_Start     (i_Start),
    .i_Dividend  (i_Dividend),
    .i_Divisor   (i_Divisor),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done),
    .o_Quotient  (o_Quotient),
    .o_Remainder (o_Remainder),
    .o_Div_Zero  (o_Div_Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; start is sampled at the following posedge, then inputs are scrambled.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    i_Dividend = a;
    i_Divisor  = b;
    i_Start    = 1'b1;
    @(posedge clk);
    #1;
    i_Start    = 1'b0;
    i_Dividend = W'($urandom);
    i_Divisor  = W'($urandom);
  endtask

  // Watches negedges after the start edge; idx is the negedge where o_Done was seen.
  task automatic wait_done(input int pulse_at, output int idx, output int bcnt);
    idx  = -1;
    bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == pulse_at) begin
        i_Start    = 1'b1;
        i_Dividend = 12'd200;
        i_Divisor  = 12'd2;
      end else begin
        i_Start = 1'b0;
      end
      if (o_Busy) bcnt++;
      if (o_Done) begin
        idx = k;
        break;
      end
    end
    i_Start = 1'b0;
    if (idx < 0) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input int idx, input int bcnt);
    int unsigned eq, er, ed, elat, ebusy;
    if (b == 0) begin
      eq = (1 << W) - 1; er = a; ed = 1; elat = 1; ebusy = 0;
    end else begin
      eq = a / b; er = a % b; ed = 0; elat = W + 1; ebusy = W;
    end
    chk({tag, ".q"}, 32'(o_Quotient), eq);
    chk({tag, ".r"}, 32'(o_Remainder), er);
    chk({tag, ".dz"}, 32'(o_Div_Zero), ed);
    chk({tag, ".lat"}, 32'(idx), elat);
    chk({tag, ".busy"}, 32'(bcnt), ebusy);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(o_Done), 32'd0);
    chk({tag, ".hold_q"}, 32'(o_Quotient), eq);
    chk({tag, ".hold_r"}, 32'(o_Remainder), er);
  endtask

  task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int idx, bcnt;
    start_op(a, b);
    wait_done(0, idx, bcnt);
    check_result(tag, a, b, idx, bcnt);
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int dcnt;
    dcnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (o_Done) dcnt++;
    end
    chk(tag, 32'(dcnt), 32'd0);
  endtask

  initial begin
    int idx, bcnt;
    logic [W-1:0] a, b;
    i_Rst_L    = 1'b0;
    i_Start    = 1'b0;
    i_Dividend = 12'd0;
    i_Divisor  = 12'd0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(o_Busy), 32'd0);
    chk("rst.done", 32'(o_Done), 32'd0);
    chk("rst.q", 32'(o_Quotient), 32'd0);
    chk("rst.r", 32'(o_Remainder), 32'd0);
    chk("rst.dz", 32'(o_Div_Zero), 32'd0);
    i_Rst_L = 1'b1;
    @(negedge clk);

    do_div("d1350_90", 12'd1350, 12'd90);
    do_div("d4095_1", 12'd4095, 12'd1);
    do_div("d7_9", 12'd7, 12'd9);
    do_div("d100_0", 12'd100, 12'd0);
    do_div("d50_7", 12'd50, 12'd7);

    start_op(12'd1000, 12'd3);
    wait_done(4, idx, bcnt);
    check_result("d1000_3", 12'd1000, 12'd3, idx, bcnt);
    expect_no_done("ign.no_second_done", 16);

    start_op(12'd2000, 12'd45);
    repeat (5) @(negedge clk);
    i_Rst_L = 1'b0;
    #1;
    chk("midrst.busy", 32'(o_Busy), 32'd0);
    chk("midrst.done", 32'(o_Done), 32'd0);
    chk("midrst.q", 32'(o_Quotient), 32'd0);
    chk("midrst.r", 32'(o_Remainder), 32'd0);
    chk("midrst.dz", 32'(o_Div_Zero), 32'd0);
    @(negedge clk);
    i_Rst_L = 1'b1;
    expect_no_done("midrst.no_done", 16);
    do_div("d2000_45", 12'd2000, 12'd45);

    // Back-to-back: each do_div returns at the first negedge in IDLE.
    do_div("b2b_a", 12'd3001, 12'd17);
    do_div("b2b_b", 12'd999, 12'd1000);

    for (int n = 0; n < 40; n++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0: b = W'($urandom_range(0, 3));
        1: b = W'($urandom_range(1, 64));
        default: b = W'($urandom);
      endcase
      do_div($sformatf("rnd%0d", n), a, b);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d want=%0d", 0, 1);
    $fatal(1, "global timeout");
  end

endmodule
